subcode_reader: RTL and testbench
=================================

SUBCODE_READER -- requirements
Module: subcode_reader

Interface
REQ-001 Parameter SYM_BITS, default 8: bits per subchannel symbol (P..W = 8).
REQ-002 Parameter FIFO_DEPTH, default 16: symbol FIFO entries; power of two, 2..64.
REQ-003 Parameter SCCK_DIV, default 2: CLK cycles per SCCK half-period; range 1..15.
REQ-004 Parameter FRAME_SYMS, default 98: symbols per subcode frame.
REQ-005 CLK  in  1  system clock; the only clock.
REQ-006 RST_n  in  1  reset, asynchronous assert, active-low.
REQ-007 ENABLE  in  1  capture enable.
REQ-008 EFFK  in  1  drive symbol strobe; asynchronous to CLK.
REQ-009 SCOR  in  1  drive subcode sync; asynchronous to CLK.
REQ-010 SBCP  in  1  drive serial subcode data; asynchronous to CLK.
REQ-011 SCCK  out  1  serial subcode clock to drive, registered.
REQ-012 RD  in  1  host pop strobe, one entry per cycle asserted.
REQ-013 DATA  out  SYM_BITS  FIFO head symbol, MSB = first bit shifted (P).
REQ-014 SYNC  out  1  FIFO head entry is the first symbol after SCOR.
REQ-015 VALID  out  1  FIFO not empty.
REQ-016 LEVEL  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 FRAME_INT  out  1  one-cycle pulse on frame completion.
REQ-018 OVERFLOW  out  1  sticky: symbol dropped, FIFO full.
REQ-019 MISSED  out  1  sticky: EFFK edge arrived during a burst.
REQ-020 CLR  in  1  synchronous clear of OVERFLOW, MISSED and symbol counter.

Function
REQ-021 EFFK, SCOR, SBCP SHALL each pass through a two-flop synchroniser; edges are detected on the synchronised value.
REQ-022 FSM states IDLE, SHIFT_HI, SHIFT_LO, STORE; IDLE -> SHIFT_HI on EFFK rising edge with ENABLE high.
REQ-023 SCCK SHALL be high exactly in SHIFT_HI, low otherwise; each phase lasts SCCK_DIV cycles.
REQ-024 SBCP (synchronised) SHALL be sampled in the last SHIFT_HI cycle, shifted in LSB-side (shift left), so first bit ends at MSB.
REQ-025 After SYM_BITS HI/LO pairs the FSM SHALL enter STORE for one cycle, push {sync_pending, shift value}, then return to IDLE.
REQ-026 Burst length: SYM_BITS*2*SCCK_DIV + 1 cycles; first SCCK rise 1 cycle after the edge-detect cycle.
REQ-027 SCOR rising edge SHALL set sync_pending; the next pushed symbol carries SYNC=1, clears sync_pending, and resets the symbol counter to 1.
REQ-028 Symbol counter increments per push; on the push making it FRAME_SYMS, FRAME_INT pulses the following cycle and the counter wraps to 0.
REQ-029 EFFK edge outside IDLE SHALL be ignored and set MISSED.
REQ-030 ENABLE low mid-burst SHALL return FSM to IDLE next cycle, SCCK low, partial symbol discarded, FIFO untouched.
REQ-031 Push while full and no RD: symbol dropped, OVERFLOW set, counter still increments.
REQ-032 Push and RD same cycle while full: both performed, no overflow, LEVEL unchanged.
REQ-033 RD while empty SHALL be ignored; DATA/SYNC then hold last value.
REQ-034 DATA/SYNC are show-ahead: valid in the same cycle as VALID, no read latency.
REQ-035 CLR and a set event in the same cycle: set wins.

Reset
REQ-036 RST_n low: FSM IDLE, SCCK 0, FIFO empty, VALID 0, LEVEL 0, DATA 0, SYNC 0, FRAME_INT 0, OVERFLOW 0, MISSED 0, sync_pending 0, counter 0, synchronisers 0.
REQ-037 Reset mid-burst SHALL force SCCK low immediately (asynchronously).

Structure
REQ-038 Package cdtv_pkg holds the FSM state enum and parameter defaults (SUBCODE_SYM_BITS, SUBCODE_FRAME_SYMS).
REQ-039 FIFO is one sub-module, sync_fifo (parametrised width/depth, show-ahead, occupancy output); the rest stays in subcode_reader.

Verification
REQ-040 Defaults, SBCP pattern 1,0,1,1,0,0,1,0 after one EFFK -> 8 SCCK pulses of 2 high/2 low, DATA=0xB2, VALID=1, LEVEL=1.
REQ-041 SCOR pulse then 98 symbols -> first entry SYNC=1, all others SYNC=0, FRAME_INT single pulse after 98th push.
REQ-042 17 symbols, no RD, FIFO_DEPTH=16 -> LEVEL=16, OVERFLOW=1, head is first symbol; CLR -> OVERFLOW=0.
REQ-043 Full FIFO, RD held during 17th STORE -> OVERFLOW=0, LEVEL=16, new tail equals 17th symbol.
REQ-044 Second EFFK edge during burst -> MISSED=1, exactly 8 SCCK pulses; ENABLE dropped after 3 pulses -> SCCK low, LEVEL unchanged.
REQ-045 RST_n asserted during SHIFT_HI -> SCCK 0 without a CLK edge, all outputs at reset values.

Source files
------------

// File: rtl/cdtv_pkg.sv
// Shared definitions for the CDTV subcode reader: FSM state encoding and
// parameter defaults.
package cdtv_pkg;
  localparam int SUBCODE_SYM_BITS   = 8;
  localparam int SUBCODE_FRAME_SYMS = 98;
  localparam int SUBCODE_FIFO_DEPTH = 16;
  localparam int SUBCODE_SCCK_DIV   = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_HI = 2'd1,
    ST_SHIFT_LO = 2'd2,
    ST_STORE    = 2'd3
  } sub_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head word and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign level  = count;
  assign rd_nxt = rd_ptr + 1'b1;
  assign do_rd  = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign do_wr  = wr && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_nxt;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head word is kept in a register so it holds its last value once drained.
      if (do_rd) begin
        if (count != ONE_CNT) dout <= mem[rd_nxt];
        else if (do_wr)       dout <= wdata;
      end else if (do_wr && empty) begin
        dout <= wdata;
      end
    end
  end
endmodule

// File: rtl/subcode_reader.sv
// Subcode reader: clocks serial subchannel symbols out of the drive on EFFK,
// tags frame sync from SCOR, and queues symbols for the host.
module subcode_reader
  import cdtv_pkg::*;
#(
  parameter int SYM_BITS   = SUBCODE_SYM_BITS,
  parameter int FIFO_DEPTH = SUBCODE_FIFO_DEPTH,
  parameter int SCCK_DIV   = SUBCODE_SCCK_DIV,
  parameter int FRAME_SYMS = SUBCODE_FRAME_SYMS
) (
  input  logic                          CLK,
  input  logic                          RST_n,
  input  logic                          ENABLE,
  input  logic                          EFFK,
  input  logic                          SCOR,
  input  logic                          SBCP,
  output logic                          SCCK,
  input  logic                          RD,
  output logic [SYM_BITS-1:0]           DATA,
  output logic                          SYNC,
  output logic                          VALID,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          FRAME_INT,
  output logic                          OVERFLOW,
  output logic                          MISSED,
  input  logic                          CLR
);
  localparam int BW = $clog2(SYM_BITS + 1);
  localparam int CW = $clog2(FRAME_SYMS + 1);
  localparam logic [3:0]    DIV_LAST  = 4'(SCCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SYM_BITS - 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_SYMS);

  logic effk_p0, effk_p1, effk_p2;
  logic scor_p0, scor_p1, scor_p2;
  logic sbcp_p0, sbcp_p1;
  logic effk_rise, scor_rise;

  sub_state_t          state;
  logic [3:0]          div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SYM_BITS-1:0] shreg;

  logic                sync_pending;
  logic [CW-1:0]       sym_cnt;
  logic [CW-1:0]       cnt_inc;
  logic                frame_hit;
  logic                push;
  logic                fifo_empty;
  logic                fifo_full;
  logic [SYM_BITS:0]   fifo_dout;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous value for edge detect
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      {effk_p0, effk_p1, effk_p2} <= '0;
      {scor_p0, scor_p1, scor_p2} <= '0;
      {sbcp_p0, sbcp_p1}          <= '0;
    end else begin
      {effk_p0, effk_p1, effk_p2} <= {EFFK, effk_p0, effk_p1};
      {scor_p0, scor_p1, scor_p2} <= {SCOR, scor_p0, scor_p1};
      {sbcp_p0, sbcp_p1}          <= {SBCP, sbcp_p0};
    end
  end

  assign effk_rise = effk_p1 & ~effk_p2;
  assign scor_rise = scor_p1 & ~scor_p2;

  // Burst FSM: SCCK is registered alongside the state so it is high exactly in SHIFT_HI
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      SCCK    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!ENABLE) begin
      state   <= ST_IDLE;
      SCCK    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (effk_rise) begin
            state   <= ST_SHIFT_HI;
            SCCK    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            shreg   <= {shreg[SYM_BITS-2:0], sbcp_p1};
            state   <= ST_SHIFT_LO;
            SCCK    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= ST_STORE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_SHIFT_HI;
              SCCK    <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_STORE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign push      = (state == ST_STORE) && ENABLE;
  assign cnt_inc   = sync_pending ? CW'(1) : sym_cnt + 1'b1;
  assign frame_hit = (cnt_inc == FRAME_CNT);

  // Status: set events take priority over CLR; dropped symbols still advance the count
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync_pending <= 1'b0;
      sym_cnt      <= '0;
      FRAME_INT    <= 1'b0;
      OVERFLOW     <= 1'b0;
      MISSED       <= 1'b0;
    end else begin
      FRAME_INT <= push && frame_hit;
      if (push)     sym_cnt <= frame_hit ? '0 : cnt_inc;
      else if (CLR) sym_cnt <= '0;
      if (scor_rise) sync_pending <= 1'b1;
      else if (push) sync_pending <= 1'b0;
      if (push && fifo_full && !RD) OVERFLOW <= 1'b1;
      else if (CLR)                 OVERFLOW <= 1'b0;
      if (effk_rise && state != ST_IDLE) MISSED <= 1'b1;
      else if (CLR)                      MISSED <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (SYM_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_n),
    .wr    (push),
    .wdata ({sync_pending, shreg}),
    .rd    (RD),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (LEVEL)
  );

  assign {SYNC, DATA} = fifo_dout;
  assign VALID        = !fifo_empty;
endmodule

// File: tb/tb_subcode_reader.sv
// Directed bench for subcode_reader: plays the drive side of the EFFK/SCCK/SBCP
// handshake and checks queue contents, sync tagging and status flags.
module tb_subcode_reader;
  logic       CLK = 1'b0;
  logic       RST_n, ENABLE, EFFK, SCOR, SBCP, RD, CLR;
  logic       SCCK, SYNC, VALID, FRAME_INT, OVERFLOW, MISSED;
  logic [7:0] DATA;
  logic [4:0] LEVEL;

  int   total = 0;
  int   bad   = 0;
  int   rises = 0;
  int   frames = 0;
  int   hi_run = 0;
  logic run_err = 1'b0;
  logic scck_q = 1'b0;
  int   base;
  int   fbase;
  logic [7:0] v;

  subcode_reader #(
    .SYM_BITS(8), .FIFO_DEPTH(16), .SCCK_DIV(2), .FRAME_SYMS(98)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .ENABLE(ENABLE), .EFFK(EFFK), .SCOR(SCOR),
    .SBCP(SBCP), .SCCK(SCCK), .RD(RD), .DATA(DATA), .SYNC(SYNC),
    .VALID(VALID), .LEVEL(LEVEL), .FRAME_INT(FRAME_INT),
    .OVERFLOW(OVERFLOW), .MISSED(MISSED), .CLR(CLR)
  );

  always #5 CLK = ~CLK;

  // SCCK pulse counter, high-phase width tracker and FRAME_INT pulse counter
  always @(negedge CLK) begin
    if (SCCK) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0 && hi_run != 2) run_err <= 1'b1;
      hi_run <= 0;
    end
    if (SCCK && !scck_q) rises <= rises + 1;
    scck_q <= SCCK;
    if (FRAME_INT) frames <= frames + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_scck(input logic lvl);
    int n = 0;
    while (SCCK !== lvl && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("scck_wait", 32'(SCCK), 32'(lvl));
  endtask

  // Drive one symbol MSB first, changing SBCP after each SCCK fall like the drive does.
  task automatic send_sym(input logic [7:0] sym, input bit dbl, input bit rd_store);
    SBCP = sym[7];
    @(negedge CLK);
    EFFK = 1'b1;
    wait_scck(1'b1);
    EFFK = 1'b0;
    for (int i = 1; i < 8; i++) begin
      wait_scck(1'b0);
      SBCP = sym[7-i];
      if (dbl && i == 2) EFFK = 1'b1;
      if (dbl && i == 4) EFFK = 1'b0;
      wait_scck(1'b1);
    end
    wait_scck(1'b0);
    @(negedge CLK);
    @(negedge CLK);
    if (rd_store) RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop();
    RD = 1'b1;
    @(negedge CLK);
    RD = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0; ENABLE = 1'b1; EFFK = 1'b0; SCOR = 1'b0;
    SBCP = 1'b0; RD = 1'b0; CLR = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_scck", 32'(SCCK), 0);
    chk("rst_valid", 32'(VALID), 0);
    chk("rst_level", 32'(LEVEL), 0);
    chk("rst_data", 32'(DATA), 0);
    chk("rst_sync", 32'(SYNC), 0);
    chk("rst_frame_int", 32'(FRAME_INT), 0);
    chk("rst_overflow", 32'(OVERFLOW), 0);
    chk("rst_missed", 32'(MISSED), 0);
    RST_n = 1'b1;
    repeat (3) @(negedge CLK);

    // Single symbol 1,0,1,1,0,0,1,0
    base = rises;
    send_sym(8'hB2, 1'b0, 1'b0);
    chk("b2_pulses", 32'(rises - base), 8);
    chk("b2_hi_width", 32'(run_err), 0);
    chk("b2_data", 32'(DATA), 32'h0B2);
    chk("b2_sync", 32'(SYNC), 0);
    chk("b2_valid", 32'(VALID), 1);
    chk("b2_level", 32'(LEVEL), 1);
    pop();
    chk("pop_valid", 32'(VALID), 0);
    chk("pop_level", 32'(LEVEL), 0);
    chk("pop_hold_data", 32'(DATA), 32'h0B2);
    pop();
    chk("empty_rd_level", 32'(LEVEL), 0);
    chk("empty_rd_data", 32'(DATA), 32'h0B2);

    // SCOR then a full 98-symbol frame
    SCOR = 1'b1;
    repeat (3) @(negedge CLK);
    SCOR = 1'b0;
    repeat (3) @(negedge CLK);
    fbase = frames;
    for (int i = 0; i < 98; i++) begin
      v = 8'(i * 37 + 5);
      send_sym(v, 1'b0, 1'b0);
      chk("frame_data", 32'(DATA), 32'(v));
      chk("frame_sync", 32'(SYNC), 32'(i == 0));
      if (i == 96) chk("frame_int_early", 32'(frames - fbase), 0);
      pop();
    end
    chk("frame_int_once", 32'(frames - fbase), 1);

    // Overflow with 17 symbols into a 16-deep queue
    for (int i = 0; i < 17; i++) send_sym(8'(8'h40 + i), 1'b0, 1'b0);
    chk("ovf_level", 32'(LEVEL), 16);
    chk("ovf_flag", 32'(OVERFLOW), 1);
    chk("ovf_head", 32'(DATA), 32'h040);
    pulse_clr();
    chk("ovf_clr", 32'(OVERFLOW), 0);
    chk("ovf_clr_level", 32'(LEVEL), 16);

    // Pop during STORE while full
    send_sym(8'hC7, 1'b0, 1'b1);
    chk("rdfull_ovf", 32'(OVERFLOW), 0);
    chk("rdfull_level", 32'(LEVEL), 16);
    chk("rdfull_head", 32'(DATA), 32'h041);
    repeat (15) pop();
    chk("rdfull_tail_level", 32'(LEVEL), 1);
    chk("rdfull_tail", 32'(DATA), 32'h0C7);
    pop();
    chk("drain_level", 32'(LEVEL), 0);

    // Second EFFK during a burst
    base = rises;
    send_sym(8'h5A, 1'b1, 1'b0);
    chk("missed_flag", 32'(MISSED), 1);
    chk("missed_pulses", 32'(rises - base), 8);
    chk("missed_data", 32'(DATA), 32'h05A);
    chk("missed_level", 32'(LEVEL), 1);
    chk("missed_hi_width", 32'(run_err), 0);
    pulse_clr();
    chk("missed_clr", 32'(MISSED), 0);

    // ENABLE dropped after three SCCK pulses
    base = rises;
    @(negedge CLK);
    EFFK = 1'b1;
    wait_scck(1'b1);
    EFFK = 1'b0;
    wait_scck(1'b0);
    wait_scck(1'b1);
    wait_scck(1'b0);
    wait_scck(1'b1);
    wait_scck(1'b0);
    ENABLE = 1'b0;
    repeat (40) @(negedge CLK);
    chk("abort_scck", 32'(SCCK), 0);
    chk("abort_pulses", 32'(rises - base), 3);
    chk("abort_level", 32'(LEVEL), 1);
    chk("abort_data", 32'(DATA), 32'h05A);
    ENABLE = 1'b1;
    repeat (3) @(negedge CLK);

    // Asynchronous reset while SCCK is high
    EFFK = 1'b1;
    wait_scck(1'b1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("arst_scck", 32'(SCCK), 0);
    chk("arst_valid", 32'(VALID), 0);
    chk("arst_level", 32'(LEVEL), 0);
    chk("arst_data", 32'(DATA), 0);
    chk("arst_sync", 32'(SYNC), 0);
    chk("arst_overflow", 32'(OVERFLOW), 0);
    chk("arst_missed", 32'(MISSED), 0);
    chk("arst_frame_int", 32'(FRAME_INT), 0);
    EFFK = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_rst_scck", 32'(SCCK), 0);
    chk("post_rst_level", 32'(LEVEL), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
